// File: rtl/jpeg_idct.sv
// 8x8 two-pass integer IDCT: row pass into ping-pong banks, column pass out as level-shifted Y.
// Define IDCT_SAT_EN to saturate intermediate and output values; otherwise they wrap.
module jpeg_idct #(
   parameter int unsigned SCALE_SHIFT = 10,
   parameter int unsigned IN_W        = 12
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   en_in_i,
   input  logic signed [IN_W-1:0] in_data_i,
   output logic signed [7:0]      out_data_o,
   output logic                   en_out_o
);

   localparam int A = 362;
   localparam int B = 502;
   localparam int C = 473;
   localparam int D = 426;
   localparam int E = 284;
   localparam int F = 196;
   localparam int G = 100;

   // Indexed {i, k}: input frequency i, output position k.
   localparam int CTab [64] = '{
      A,  A,  A,  A,  A,  A,  A,  A,
      B,  D,  E,  G, -G, -E, -D, -B,
      C,  F, -F, -C, -C, -F,  F,  C,
      D, -G, -B, -E,  E,  B,  G, -D,
      A, -A, -A,  A,  A, -A, -A,  A,
      E, -B,  G,  D, -D, -G,  B, -E,
      F, -C,  C, -F, -F,  C, -C,  F,
      G, -E,  D, -B,  B, -D,  E, -G
   };

   function automatic int coef(input logic [2:0] k, input logic [2:0] i);
      return CTab[{i, k}];
   endfunction

   // Signed division by 2^SCALE_SHIFT rounding toward zero.
   function automatic int div_tz(input int s);
      int mag;
      mag = (s < 0) ? -s : s;
      mag = mag >> SCALE_SHIFT;
      return (s < 0) ? -mag : mag;
   endfunction

   function automatic logic signed [9:0] lim10(input int v);
`ifdef IDCT_SAT_EN
      if (v > 511) return 10'h1ff;
      else if (v < -512) return 10'h200;
      else return v[9:0];
`else
      return v[9:0];
`endif
   endfunction

   function automatic logic signed [7:0] lim8(input int v);
`ifdef IDCT_SAT_EN
      if (v > 127) return 8'h7f;
      else if (v < -128) return 8'h80;
      else return v[7:0];
`else
      return v[7:0];
`endif
   endfunction

   logic        [5:0]      n_q, n_d;
   logic signed [IN_W-1:0] x_q [7];
   logic signed [IN_W-1:0] x_d [7];
   logic                   in_bank_q, in_bank_d;

   logic signed [IN_W-1:0] s1_row_q [8];
   logic signed [IN_W-1:0] s1_row_d [8];
   logic                   s1_busy_q, s1_busy_d;
   logic        [2:0]      s1_k_q, s1_k_d;
   logic        [2:0]      s1_col_q, s1_col_d;
   logic                   s1_bank_q, s1_bank_d;
   int                     s1_sum;
   logic signed [9:0]      s1_val;

   logic        [1:0]      full_q, full_d;
   logic signed [9:0]      mem_q [2][8][8];

   logic                   s2_busy_q, s2_busy_d;
   logic                   s2_sel_q, s2_sel_d;
   logic        [2:0]      s2_r_q, s2_r_d;
   logic        [2:0]      s2_k_q, s2_k_d;
   logic signed [9:0]      s2_row_q [8];
   logic signed [9:0]      s2_row_d [8];
   int                     s2_sum;
   logic signed [7:0]      s2_val;
   logic                   s2_load;
   logic                   s2_load_bank;
   logic        [2:0]      s2_load_row;

   logic signed [7:0]      out_q, out_d;
   logic                   en_out_q, en_out_d;

   always_comb begin
      s1_sum = 0;
      for (int i = 0; i < 8; i++) begin
         s1_sum = s1_sum + coef(s1_k_q, 3'(i)) * int'(s1_row_q[i]);
      end
      s1_val = lim10(div_tz(s1_sum));
      s2_sum = 0;
      for (int i = 0; i < 8; i++) begin
         s2_sum = s2_sum + coef(s2_k_q, 3'(i)) * int'(s2_row_q[i]);
      end
      s2_val = lim8(div_tz(s2_sum));
   end

   always_comb begin
      n_d          = n_q;
      x_d          = x_q;
      in_bank_d    = in_bank_q;
      s1_row_d     = s1_row_q;
      s1_busy_d    = s1_busy_q;
      s1_k_d       = s1_k_q;
      s1_col_d     = s1_col_q;
      s1_bank_d    = s1_bank_q;
      full_d       = full_q;
      s2_busy_d    = s2_busy_q;
      s2_sel_d     = s2_sel_q;
      s2_r_d       = s2_r_q;
      s2_k_d       = s2_k_q;
      s2_row_d     = s2_row_q;
      s2_load      = 1'b0;
      s2_load_bank = s2_sel_q;
      s2_load_row  = 3'd0;
      out_d        = out_q;
      en_out_d     = 1'b0;

      if (s1_busy_q) begin
         s1_k_d = s1_k_q + 3'd1;
         if (s1_k_q == 3'd7) begin
            s1_busy_d = 1'b0;
            if (s1_col_q == 3'd7) full_d[s1_bank_q] = 1'b1;
         end
      end

      if (en_in_i) begin
         n_d = n_q + 6'd1;
         if (n_q[2:0] != 3'd7) begin
            x_d[n_q[2:0]] = in_data_i;
         end else begin
            for (int i = 0; i < 7; i++) s1_row_d[i] = x_q[i];
            s1_row_d[7] = in_data_i;
            s1_busy_d   = 1'b1;
            s1_k_d      = 3'd0;
            s1_col_d    = n_q[5:3];
            s1_bank_d   = in_bank_q;
            if (n_q == 6'd63) in_bank_d = ~in_bank_q;
         end
      end

      if (s2_busy_q) begin
         en_out_d = 1'b1;
         out_d    = s2_val;
         s2_k_d   = s2_k_q + 3'd1;
         if (s2_k_q == 3'd7) begin
            if (s2_r_q != 3'd7) begin
               s2_load     = 1'b1;
               s2_load_row = s2_r_q + 3'd1;
               // Last row captured: stage 1 may refill this bank from here on.
               if (s2_r_q == 3'd6) full_d[s2_sel_q] = 1'b0;
            end else begin
               s2_sel_d  = ~s2_sel_q;
               s2_busy_d = 1'b0;
               if (full_q[~s2_sel_q]) begin
                  s2_load      = 1'b1;
                  s2_load_bank = ~s2_sel_q;
               end
            end
         end
      end else if (full_q[s2_sel_q]) begin
         s2_load = 1'b1;
      end

      if (s2_load) begin
         s2_busy_d = 1'b1;
         s2_r_d    = s2_load_row;
         s2_k_d    = 3'd0;
         for (int i = 0; i < 8; i++) s2_row_d[i] = mem_q[s2_load_bank][s2_load_row][i];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         n_q       <= '0;
         x_q       <= '{default: '0};
         in_bank_q <= 1'b0;
         s1_row_q  <= '{default: '0};
         s1_busy_q <= 1'b0;
         s1_k_q    <= '0;
         s1_col_q  <= '0;
         s1_bank_q <= 1'b0;
         full_q    <= '0;
         s2_busy_q <= 1'b0;
         s2_sel_q  <= 1'b0;
         s2_r_q    <= '0;
         s2_k_q    <= '0;
         s2_row_q  <= '{default: '0};
         out_q     <= '0;
         en_out_q  <= 1'b0;
      end else begin
         n_q       <= n_d;
         x_q       <= x_d;
         in_bank_q <= in_bank_d;
         s1_row_q  <= s1_row_d;
         s1_busy_q <= s1_busy_d;
         s1_k_q    <= s1_k_d;
         s1_col_q  <= s1_col_d;
         s1_bank_q <= s1_bank_d;
         full_q    <= full_d;
         s2_busy_q <= s2_busy_d;
         s2_sel_q  <= s2_sel_d;
         s2_r_q    <= s2_r_d;
         s2_k_q    <= s2_k_d;
         s2_row_q  <= s2_row_d;
         out_q     <= out_d;
         en_out_q  <= en_out_d;
      end
   end

   // Bank contents are never read unless marked full, so they carry no reset.
   always_ff @(posedge clk_i) begin
      if (s1_busy_q) mem_q[s1_bank_q][s1_k_q][s1_col_q] <= s1_val;
   end

   assign out_data_o = out_q;
   assign en_out_o   = en_out_q;

endmodule

// File: doc/jpeg_idct.md
JPEG_IDCT -- requirements
Module: jpeg_idct

Interface
REQ-001 SCALE_SHIFT, default 10, fixed-point fraction bits; every product sum is divided by 2^SCALE_SHIFT.
REQ-002 IN_W, default 12, width of the signed DCT coefficient input.
REQ-003 Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 En_In  input  1  qualifies In_Data for one cycle.
REQ-006 In_Data  input  IN_W  signed coefficient, 64 per 8x8 block, row-major index n=0..63 (row j=n/8, col i=n%8).
REQ-007 Out_Data  output  8  signed reconstructed Y sample (level-shifted, range -128..127).
REQ-008 En_Out  output  1  qualifies Out_Data; 64 per block, row-major pixel order.

Function
REQ-009 Constants SHALL be a=362, b=502, c=473, d=426, e=284, f=196, g=100.
REQ-010 Basis C[k][i] for output k=0..7 SHALL be: i0 a,a,a,a,a,a,a,a; i1 b,d,e,g,-g,-e,-d,-b; i2 c,f,-f,-c,-c,-f,f,c; i3 d,-g,-b,-e,e,b,g,-d; i4 a,-a,-a,a,a,-a,-a,a; i5 e,-b,g,d,-d,-g,b,-e; i6 f,-c,c,-f,-f,c,-c,f; i7 g,-e,d,-b,b,-d,e,-g.
REQ-011 Stage 1: when the 8th coefficient of row j is accepted, the row SHALL be latched; over the next 8 cycles M[k][j]=lim10(sum_i C[k][i]*X[j][i] / 1024), one k per cycle, written into column j of the intermediate bank.
REQ-012 Stage 2: row r of a complete bank SHALL be latched as a whole, then Y[r][k]=lim8(sum_i C[k][i]*M[r][i] / 1024) emitted for k=0..7, one per cycle.
REQ-013 Division SHALL truncate toward zero (signed integer division, not arithmetic shift); sums held at full precision, no intermediate truncation.
REQ-014 Intermediate storage SHALL be two 64x10-bit banks (ping-pong); stage 1 fills one while stage 2 drains the other.
REQ-015 Throughput: one coefficient per cycle sustained indefinitely; no back-pressure port; gaps in En_In allowed anywhere.
REQ-016 Latency: first En_Out of a block SHALL be asserted exactly 10 cycles after the edge sampling that block's 64th coefficient; then 64 consecutive cycles of En_Out.
REQ-017 Back-to-back blocks SHALL produce back-to-back output with no gap and no bank corruption (stage 2 row latch precedes any stage-1 overwrite).
REQ-018 Out_Data and En_Out SHALL be registered; Out_Data SHALL hold its last value while En_Out is low.
REQ-019 Coefficient and block counters SHALL wrap 63->0 and bank select toggles on every completed block.
REQ-020 En_In while stage 2 is idle or busy SHALL be accepted identically.

Reset
REQ-021 Reset SHALL force Out_Data=0, En_Out=0, all counters 0, bank select 0, both banks marked empty.
REQ-022 Reset mid-block SHALL discard all partial input and pending output; the first coefficient after Reset deasserts is n=0 of a new block.
REQ-023 Bank contents need not be cleared by reset; no output may be derived from pre-reset data.

Configuration
REQ-024 Macro IDCT_SAT_EN defined: lim10 saturates to [-512,511], lim8 saturates to [-128,127].
REQ-025 IDCT_SAT_EN undefined: lim10/lim8 SHALL keep the low 10/8 bits (two's-complement wrap); no comparators synthesized.

Verification
REQ-026 DC block coef[0]=800, others 0 -> 64 outputs all 99; coef[0]=-800 -> all -99 (truncation toward zero).
REQ-027 coef[0]=2047 -> with IDCT_SAT_EN all 64 outputs 127; without it, stage-1 value 723 wraps to -301, all outputs -106.
REQ-028 All-zero block -> 64 outputs of 0, En_Out exactly 10 cycles after 64th input edge.
REQ-029 Three blocks streamed continuously (192 cycles) -> 192 consecutive En_Out cycles, each block matches software model.
REQ-030 En_In at 50% duty with random block data -> 64 outputs per block, values match model, order row-major.
REQ-031 Reset asserted after 30 coefficients -> En_Out=0, Out_Data=0 immediately; following DC-800 block yields 64 x 99.
